// File: rtl/prewish_mentor.sv
// Wishbone-style upstream sequencer for the blinky student: resets it, then strobes a table
// of LED masks into it with a dwell between loads. A debounced active-low button skips ahead.
//
// state   | meaning
// S_RST   | holding the student in reset after internal reset release
// S_LOAD  | strobing the current mask into the student
// S_DWELL | idle between loads; a button press cuts this short
module prewish_mentor #(
  parameter int                        NUM_PATTERNS  = 4,
  parameter logic [8*NUM_PATTERNS-1:0] PATTERNS      = 32'h80F0AAFF,
  parameter int                        RST_CYCLES    = 4,
  parameter int                        STB_CYCLES    = 2,
  parameter logic [23:0]               DWELL_CYCLES  = 24'd12000000,
  parameter int                        DEBOUNCE_BITS = 16
) (
  input  logic       CLK_I,
  input  logic       iN_RST_I,
  input  logic       iN_btn,
  output logic       RST_O,
  output logic       STB_O,
  output logic [7:0] DAT_O,
  output logic [3:0] pattern_idx
);

  localparam int PHASE_MAX = (RST_CYCLES > STB_CYCLES) ? RST_CYCLES : STB_CYCLES;
  localparam int PW        = (PHASE_MAX > 1) ? $clog2(PHASE_MAX) : 1;

  localparam logic [PW-1:0] RST_LAST   = PW'(RST_CYCLES - 1);
  localparam logic [PW-1:0] STB_LAST   = PW'(STB_CYCLES - 1);
  localparam logic [3:0]    LAST_IDX   = 4'(NUM_PATTERNS - 1);
  localparam logic [23:0]   DWELL_LAST = DWELL_CYCLES - 24'd1;

  typedef enum logic [1:0] {S_RST, S_LOAD, S_DWELL} state_t;

  function automatic logic [7:0] entry(input logic [3:0] k);
    logic [8*NUM_PATTERNS-1:0] shifted;
    shifted = PATTERNS >> {k, 3'b000};
    return shifted[7:0];
  endfunction

  // Reset asserts immediately but releases two edges after the pin rises.
  logic [1:0] rst_sync;
  logic       rst_n;

  always_ff @(posedge CLK_I or negedge iN_RST_I) begin
    if (!iN_RST_I) rst_sync <= 2'b00;
    else           rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_n = rst_sync[1];

  logic [1:0]               btn_sync;
  logic                     btn_pressed;
  logic                     deb_pressed;
  logic [DEBOUNCE_BITS-1:0] deb_cnt;
  logic                     press;

  always_ff @(posedge CLK_I or negedge rst_n) begin
    if (!rst_n) btn_sync <= 2'b11;
    else        btn_sync <= {btn_sync[0], iN_btn};
  end

  assign btn_pressed = ~btn_sync[1];

  // Debounced level flips only after a full window of disagreeing samples.
  always_ff @(posedge CLK_I or negedge rst_n) begin
    if (!rst_n) begin
      deb_pressed <= 1'b0;
      deb_cnt     <= '0;
      press       <= 1'b0;
    end else begin
      press <= 1'b0;
      if (btn_pressed == deb_pressed) begin
        deb_cnt <= '0;
      end else if (deb_cnt == '1) begin
        deb_cnt     <= '0;
        deb_pressed <= btn_pressed;
        press       <= btn_pressed;
      end else begin
        deb_cnt <= deb_cnt + 1'b1;
      end
    end
  end

  state_t      state;
  logic [PW-1:0] phase_cnt;
  logic [23:0] dwell_cnt;
  logic [3:0]  next_idx;

  assign next_idx = (pattern_idx == LAST_IDX) ? 4'd0 : pattern_idx + 4'd1;

  always_ff @(posedge CLK_I or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_RST;
      phase_cnt   <= '0;
      dwell_cnt   <= '0;
      RST_O       <= 1'b1;
      STB_O       <= 1'b0;
      DAT_O       <= 8'h00;
      pattern_idx <= 4'd0;
    end else begin
      case (state)
        S_RST: begin
          if (phase_cnt == RST_LAST) begin
            phase_cnt   <= '0;
            RST_O       <= 1'b0;
            STB_O       <= 1'b1;
            DAT_O       <= entry(4'd0);
            pattern_idx <= 4'd0;
            state       <= S_LOAD;
          end else begin
            phase_cnt <= phase_cnt + 1'b1;
          end
        end
        S_LOAD: begin
          if (phase_cnt == STB_LAST) begin
            phase_cnt <= '0;
            STB_O     <= 1'b0;
            state     <= S_DWELL;
          end else begin
            phase_cnt <= phase_cnt + 1'b1;
          end
        end
        S_DWELL: begin
          // A press landing on the terminal count still yields a single advance.
          if (press || dwell_cnt == DWELL_LAST) begin
            dwell_cnt   <= '0;
            STB_O       <= 1'b1;
            DAT_O       <= entry(next_idx);
            pattern_idx <= next_idx;
            state       <= S_LOAD;
          end else begin
            dwell_cnt <= dwell_cnt + 24'd1;
          end
        end
        default: begin
          state     <= S_RST;
          phase_cnt <= '0;
          dwell_cnt <= '0;
          RST_O     <= 1'b1;
          STB_O     <= 1'b0;
        end
      endcase
    end
  end

endmodule
